imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_sync_ff.sv | 23 ++
 rtl/imem_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned STB_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitStb,
    StWrite,
    StWaitLow,
    StFullSt,
    StRelease
  } state_e;

endpackage

// File: rtl/imem_loader_sync_ff.sv
// Reset-to-zero flop chain for bringing an asynchronous level into the CLK domain.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/imem_loader.sv
// Loads instruction words from a GPIO strobe handshake into instruction memory while
// holding the core in reset. Define IMEM_LOADER_CHECKSUM_EN to build the XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic              STB,
  input  logic [STB_W-1:0]  W_Ins,
  output logic              ACK,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [STB_W-1:0]  IM_WDATA,
  output logic              CPU_RST,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              DONE,
  output logic [STB_W-1:0]  CHKSUM
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

  logic              w_we_s;
  logic              w_stb_s;
  logic              w_we_rise;
  logic              w_stb_rise;
  logic              w_capture;
  state_e            r_state;
  state_e            w_state_d;
  logic              r_we_prev;
  logic              r_stb_prev;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [STB_W-1:0]  r_data;
  logic              r_full;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_d     (WE),
    .o_q     (w_we_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_d     (STB),
    .o_q     (w_stb_s)
  );

  assign w_we_rise  = w_we_s && !r_we_prev;
  assign w_stb_rise = w_stb_s && !r_stb_prev;
  assign w_capture  = (r_state == StWaitStb) && w_we_s && w_stb_rise;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_we_rise) w_state_d = StArm;
      StArm:     w_state_d = w_we_s ? StWaitStb : StRelease;
      StWaitStb: begin
        if (!w_we_s)         w_state_d = StRelease;
        else if (w_stb_rise) w_state_d = StWrite;
      end
      // A write already under way always completes before release.
      StWrite:   w_state_d = w_we_s ? StWaitLow : StRelease;
      StWaitLow: begin
        if (!w_we_s)       w_state_d = StRelease;
        else if (!w_stb_s) w_state_d = (r_count == DepthCnt) ? StFullSt : StWaitStb;
      end
      StFullSt:  if (!w_we_s) w_state_d = StRelease;
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_we_prev  <= 1'b0;
      r_stb_prev <= 1'b0;
      r_count    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_full     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_we_prev  <= w_we_s;
      r_stb_prev <= w_stb_s;
      if (r_state == StArm) begin
        r_count <= '0;
        r_addr  <= '0;
        r_full  <= 1'b0;
      end
      if (w_capture) begin
        r_data <= W_Ins;
        r_addr <= r_count[ADDR_W-1:0];
      end
      if (r_state == StWrite) r_count <= r_count + (ADDR_W + 1)'(1);
      if ((r_state == StWaitLow) && (w_state_d == StFullSt)) r_full <= 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [STB_W-1:0] r_chksum;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_chksum <= '0;
    end else if (r_state == StArm) begin
      r_chksum <= '0;
    end else if (r_state == StWrite) begin
      r_chksum <= r_chksum ^ r_data;
    end
  end

  assign CHKSUM = r_chksum;
`else
  assign CHKSUM = '0;
`endif

  assign ACK      = (r_state == StWaitLow);
  assign IM_WE    = (r_state == StWrite);
  assign IM_ADDR  = r_addr;
  assign IM_WDATA = r_data;
  assign COUNT    = r_count;
  assign FULL     = r_full;
  assign DONE     = (r_state == StRelease);
  // Core is held whenever a session is active, and also while RST is asserted.
  assign CPU_RST  = !RST || (r_state != StIdle);

endmodule
